// File: rtl/countdown_timer_pkg.sv
// Shared types and default parameters for the countdown timer slice.
package countdown_timer_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, control and status bundle of the countdown timer.
// The master side offers start values and controls; the slave side is the timer.
interface countdown_timer_if
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output load_valid, data, enable, abort,
    input  load_ready, count, busy, done, tc
  );

  modport slave (
    input  load_valid, data, enable, abort,
    output load_ready, count, busy, done, tc
  );

endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides enabled cycles down to one decrement tick every PRESCALE enabled
// cycles. With PRESCALE==1 the tick is simply the enable itself.
module tick_prescaler
  import countdown_timer_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;

  // A pause holds ps_cnt, so re-enabling never produces a tick by itself.
  assign tick = enable && ((PRESCALE == 1) || (ps_cnt == PS_LAST));

  // Prescale counter: clears on request, wraps on tick, advances on enabled cycles.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      ps_cnt <= '0;
    else if (clear)  ps_cnt <= '0;
    else if (tick)   ps_cnt <= '0;
    else if (enable) ps_cnt <= ps_cnt + PS_W'(1);
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter: accepts a start value over valid/ready, decrements on
// prescaled enable ticks and pulses tc when the count reaches zero.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN for periodic mode, where the
// count reloads the last start value on terminal count and stays running.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input logic            clock,
  input logic            reset,
  countdown_timer_if.slave tmr
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             tc_q, tc_nxt;
  logic             load_acc;
  logic             tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_nxt;
`endif

  // Abort outranks a concurrent load; loads are only taken outside RUN.
  assign load_acc = tmr.load_valid && !tmr.abort && (state != RUN);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (load_acc || tmr.abort),
    .enable (tmr.enable && (state == RUN)),
    .tick   (tick)
  );

  // State, count, reload value and terminal-count pulse registers.
  // NOTE: reset is asynchronous and active-low, so it appears in the sensitivity list.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count_q  <= '0;
      tc_q     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state    <= state_nxt;
      count_q  <= count_nxt;
      tc_q     <= tc_nxt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_nxt;
`endif
    end
  end

  // Next-state and next-count logic; tc is a one-cycle pulse by default.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
    tc_nxt     = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_nxt = reload_q;
`endif
    if (tmr.abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (load_acc) begin
            count_nxt  = tmr.data;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_nxt = tmr.data;
`endif
            if (tmr.data == '0) begin
              state_nxt = DONE;
              tc_nxt    = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (tick) begin
            if (count_q == WIDTH'(1)) begin
              tc_nxt    = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_nxt = reload_q;
`else
              count_nxt = '0;
              state_nxt = DONE;
`endif
            end else begin
              count_nxt = count_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign tmr.load_ready = (state != RUN);
  assign tmr.busy       = (state == RUN);
  assign tmr.done       = (state == DONE);
  assign tmr.count      = count_q;
  assign tmr.tc         = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: one PRESCALE=1 and one PRESCALE=4
// instance. Expected per-cycle outputs are pushed to a scoreboard queue when a
// load is driven and popped as the DUT advances.
module tb_countdown_timer;

  typedef struct {
    logic [7:0] count;
    logic       tc;
    logic       done;
    logic       busy;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  countdown_timer_if #(.WIDTH(8)) if1 ();
  countdown_timer_if #(.WIDTH(8)) if4 ();

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) u_p1 (
    .clock (clock),
    .reset (reset),
    .tmr   (if1)
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) u_p4 (
    .clock (clock),
    .reset (reset),
    .tmr   (if4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Idle-state outputs of the PRESCALE=1 instance.
  task automatic check_idle1(input string tag);
    check({tag, ".count"},      32'(if1.count), 32'd0);
    check({tag, ".load_ready"}, 32'(if1.load_ready), 32'd1);
    check({tag, ".busy"},       32'(if1.busy), 32'd0);
    check({tag, ".done"},       32'(if1.done), 32'd0);
    check({tag, ".tc"},         32'(if1.tc), 32'd0);
  endtask

  // Offer a start value for exactly one edge on the PRESCALE=1 instance.
  task automatic load_p1(input logic [7:0] v);
    if1.load_valid = 1'b1;
    if1.data       = v;
    @(posedge clock);
    #1 if1.load_valid = 1'b0;
  endtask

  // One-shot expectations: v, v-1, ..., 0 with tc on 0, then one quiet cycle.
  function automatic void push_oneshot(input int v);
    for (int i = v; i >= 0; i--)
      sb.push_back('{count: 8'(i), tc: (i == 0), done: (i == 0), busy: (i != 0)});
    sb.push_back('{count: 8'd0, tc: 1'b0, done: 1'b1, busy: 1'b0});
  endfunction

  task automatic drain_p1(input string tag);
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clock);
      check({tag, ".count"}, 32'(if1.count), 32'(e.count));
      check({tag, ".tc"},    32'(if1.tc),    32'(e.tc));
      check({tag, ".done"},  32'(if1.done),  32'(e.done));
      check({tag, ".busy"},  32'(if1.busy),  32'(e.busy));
      check({tag, ".ready"}, 32'(if1.load_ready), 32'(!e.busy));
    end
  endtask

  initial begin
    int   pat[13] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    int   mc, mps, en_seen, en_at_tc;
    logic mtc;
    exp_t e;

    {if1.load_valid, if1.enable, if1.abort} = 3'b000;
    {if4.load_valid, if4.enable, if4.abort} = 3'b000;
    if1.data = '0;
    if4.data = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check_idle1("rst");
    check("rst4.count", 32'(if4.count), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Reset mid-run: outputs return before any clock edge
    if1.enable = 1'b1;
    load_p1(8'd100);
    repeat (2) @(negedge clock);
    check("midrun.busy", 32'(if1.busy), 32'd1);
    #2 reset = 1'b0;
    #1 check_idle1("midrst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_idle1("postrst");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // One-shot countdown from 3
    load_p1(8'd3);
    push_oneshot(3);
    drain_p1("oneshot3");
`endif

    // Load while running is ignored; abort wins over a concurrent load
    load_p1(8'd10);
    @(negedge clock);
    check("run.count", 32'(if1.count), 32'd10);
    check("run.ready", 32'(if1.load_ready), 32'd0);
    if1.load_valid = 1'b1;
    if1.data       = 8'd3;
    @(negedge clock);
    check("ignload.count", 32'(if1.count), 32'd9);
    check("ignload.ready", 32'(if1.load_ready), 32'd0);
    if1.abort = 1'b1;
    @(negedge clock);
    check_idle1("abort_run");
    @(negedge clock);
    check_idle1("abort_idle_load");
    if1.abort      = 1'b0;
    if1.load_valid = 1'b0;
    @(negedge clock);
    check_idle1("after_abort");

    // Zero start value: DONE and tc on the accepting edge
    load_p1(8'd0);
    push_oneshot(0);
    drain_p1("zero");

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Maximum start value: tc exactly 255 cycles after accept
    load_p1(8'hFF);
    push_oneshot(255);
    drain_p1("max");
`else
    // Periodic mode: 2,1,2,1... with tc on every reload, busy until abort
    load_p1(8'd2);
    mc = 2;
    sb.push_back('{count: 8'd2, tc: 1'b0, done: 1'b0, busy: 1'b1});
    for (int i = 0; i < 7; i++) begin
      mtc = (mc == 1);
      mc  = (mc == 1) ? 2 : mc - 1;
      sb.push_back('{count: 8'(mc), tc: mtc, done: 1'b0, busy: 1'b1});
    end
    drain_p1("reload");
    if1.abort = 1'b1;
    @(negedge clock);
    check_idle1("reload_abort");
    if1.abort = 1'b0;
`endif

    // PRESCALE=4, start value 2, pause mid-run
    if4.load_valid = 1'b1;
    if4.data       = 8'd2;
    if4.enable     = 1'b1;
    @(posedge clock);
    #1 if4.load_valid = 1'b0;
    @(negedge clock);
    check("ps4.accept", 32'(if4.count), 32'd2);
    mc = 2; mps = 0; en_seen = 0; en_at_tc = -1;
    for (int c = 0; c < 13; c++) begin
      if4.enable = pat[c][0];
      mtc = 1'b0;
      if (pat[c] != 0) begin
        if (mps == 3) begin
          mps = 0;
          if (mc == 1) begin
            mtc = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            mc = 2;
`else
            mc = 0;
`endif
          end else mc = mc - 1;
        end else mps = mps + 1;
      end
      sb.push_back('{count: 8'(mc), tc: mtc, done: 1'b0, busy: 1'b0});
      @(negedge clock);
      e = sb.pop_front();
      en_seen += pat[c];
      check($sformatf("ps4.c%0d.count", c), 32'(if4.count), 32'(e.count));
      check($sformatf("ps4.c%0d.tc", c),    32'(if4.tc),    32'(e.tc));
      if (if4.tc === 1'b1) en_at_tc = en_seen;
    end
    check("ps4.enabled_cycles", 32'(en_at_tc), 32'd8);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
    check("ps4.done", 32'(if4.done), 32'd1);
    check("ps4.ready", 32'(if4.load_ready), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
